pcs_descramble: RTL and testbench

- Stream-cipher descrambler (X3.263 scrambler, x^11 + x^9 + 1) between the NRZI-decoding PMA and the PCS receive process.
- Takes scrambled bits at 0–2 bits per clock.
- Acquires and holds LFSR synchronisation from the idle stream.
- Emits descrambled bits/bits_valid plus a link_status that feeds the PCS receiver directly.

---
 rtl/pcs_descramble_if.sv | 28 ++
 rtl/pcs_descramble.sv | 148 ++++++++++++++
 tb/tb_pcs_descramble.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcs_descramble_if.sv
// Scrambled-bit input and descrambled-bit output bundle for pcs_descramble.
// The master drives the PMA side; the slave is the descrambler.
interface pcs_descramble_if;
    logic       signal_status;
    logic [1:0] scr_bits;
    logic [1:0] scr_bits_valid;
    logic [1:0] bits;
    logic [1:0] bits_valid;
    logic       link_status;

    modport master (
        output signal_status,
        output scr_bits,
        output scr_bits_valid,
        input  bits,
        input  bits_valid,
        input  link_status
    );

    modport slave (
        input  signal_status,
        input  scr_bits,
        input  scr_bits_valid,
        output bits,
        output bits_valid,
        output link_status
    );
endinterface

// File: rtl/pcs_descramble.sv
// X3.263 stream descrambler (x^11 + x^9 + 1), 0-2 bits per clock.
// Acquires LFSR lock from the idle stream and holds it while idle keeps arriving.
module pcs_descramble #(
    parameter int LOCK_BITS = 60,
    parameter int IDLE_BITS = 29,
    parameter int TIMEOUT   = 90000
) (
    input logic             clk,
    input logic             rst_n,
    pcs_descramble_if.slave bus
);
    localparam int RW = $clog2(LOCK_BITS + 1);
    localparam int OW = $clog2(IDLE_BITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [RW-1:0] RUN_MAX  = RW'(LOCK_BITS);
    localparam logic [OW-1:0] ONES_MAX = OW'(IDLE_BITS);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_e;

    typedef struct packed {
        state_e        st;
        logic [10:0]   l;
        logic [RW-1:0] run;
        logic [OW-1:0] ones;
        logic          idle;
        logic          p;
    } ctx_t;

    state_e        state_q, state_d;
    logic [10:0]   lfsr_q, lfsr_d;
    logic [RW-1:0] run_q, run_d;
    logic [OW-1:0] ones_q, ones_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    bits_q, bits_d;
    logic [1:0]    bv_q, bv_d;
    logic          link_q, link_d;

    state_e eff_w;
    logic   sig_w;
    logic   n1_w, n2_w;
    ctx_t   c0_w, c1_w, c2_w;

    // One bit through the descrambler; the second bit of a cycle sees the first's result.
    function automatic ctx_t step(ctx_t x, logic c, logic sig);
        ctx_t y;
        logic k;
        y   = x;
        k   = x.l[10] ^ x.l[8];
        y.p = c ^ k;
        if (x.st == UNLOCKED) begin
            y.l = {x.l[9:0], ~c};
            if (~c == k) begin
                y.run = (x.run == RUN_MAX) ? x.run : x.run + 1'b1;
            end else begin
                y.run = '0;
            end
            if (y.run == RUN_MAX && sig) begin
                y.st   = LOCKED;
                y.ones = '0;
            end
        end else begin
            y.l = {x.l[9:0], k};
            if (y.p) begin
                y.ones = (x.ones == ONES_MAX) ? x.ones : x.ones + 1'b1;
            end else begin
                y.ones = '0;
            end
            if (y.ones == ONES_MAX) begin
                y.idle = 1'b1;
            end
        end
        return y;
    endfunction

    assign sig_w = bus.signal_status;
    assign n1_w  = |bus.scr_bits_valid;
    assign n2_w  = bus.scr_bits_valid[1];
    assign eff_w = sig_w ? state_q : UNLOCKED;

    assign c0_w = '{
        st:   eff_w,
        l:    lfsr_q,
        run:  run_q,
        ones: ones_q,
        idle: (eff_w == LOCKED) && (ones_q == ONES_MAX) && !n1_w,
        p:    1'b1
    };
    assign c1_w = n1_w ? step(c0_w, bus.scr_bits[1], sig_w) : c0_w;
    assign c2_w = n2_w ? step(c1_w, bus.scr_bits[0], sig_w) : c1_w;

    always_comb begin
        state_d = c2_w.st;
        lfsr_d  = c2_w.l;
        run_d   = c2_w.run;
        ones_d  = c2_w.ones;
        timer_d = timer_q;
        if (eff_w == UNLOCKED || c2_w.idle) begin
            timer_d = '0;
        end else if (timer_q != TO_MAX) begin
            timer_d = timer_q + 1'b1;
        end
        if (eff_w == LOCKED && timer_d == TO_MAX) begin
            state_d = UNLOCKED;
            run_d   = '0;
        end
        if (!sig_w) begin
            state_d = UNLOCKED;
            run_d   = '0;
        end
        bits_d = {c1_w.p, n2_w ? c2_w.p : 1'b1};
        bv_d   = 2'b00;
        if (eff_w == LOCKED && state_d == LOCKED) begin
            bv_d = {n2_w, n1_w & ~n2_w};
        end
        link_d = (state_d == LOCKED) && sig_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNLOCKED;
            lfsr_q  <= 11'h000;
            run_q   <= '0;
            ones_q  <= '0;
            timer_q <= '0;
            bits_q  <= 2'b11;
            bv_q    <= 2'b00;
            link_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            run_q   <= run_d;
            ones_q  <= ones_d;
            timer_q <= timer_d;
            bits_q  <= bits_d;
            bv_q    <= bv_d;
            link_q  <= link_d;
        end
    end

    assign bus.bits        = bits_q;
    assign bus.bits_valid  = bv_q;
    assign bus.link_status = link_q;
endmodule

// File: tb/tb_pcs_descramble.sv
// Directed bench for pcs_descramble: acquisition, framing, signal loss,
// idle timeout (second instance with TIMEOUT=100), bit error and async reset.
module tb_pcs_descramble;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig = 1'b1;
    logic [1:0]  sb = 2'b00;
    logic [1:0]  sv = 2'b00;
    logic [10:0] scr = 11'h7FF;
    int          vecs = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    pcs_descramble_if if_a ();
    pcs_descramble_if if_b ();

    assign if_a.signal_status  = sig;
    assign if_a.scr_bits       = sb;
    assign if_a.scr_bits_valid = sv;
    assign if_b.signal_status  = sig;
    assign if_b.scr_bits       = sb;
    assign if_b.scr_bits_valid = sv;

    pcs_descramble dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    pcs_descramble #(.TIMEOUT(100)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    // Reference scrambler: key = s[10]^s[8], state shifts in the key.
    task automatic enc(input logic p, output logic c);
        logic k;
        k   = scr[10] ^ scr[8];
        c   = p ^ k;
        scr = {scr[9:0], k};
    endtask

    task automatic send(input logic p1, input logic p0,
                        input logic [1:0] v, input logic flip1);
        logic c1, c0;
        c1 = 1'b1;
        c0 = 1'b1;
        if (v != 2'd0) begin
            enc(p1, c1);
            c1 = c1 ^ flip1;
        end
        if (v == 2'd2) enc(p0, c0);
        sb = {c1, c0};
        sv = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        sv = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if (if_a.bits !== 2'b11) begin
            errs++;
            $display("FAIL rst_bits: got %b want 11", if_a.bits);
        end
        vecs++;
        if (if_a.bits_valid !== 2'b00) begin
            errs++;
            $display("FAIL rst_bv: got %0d want 0", if_a.bits_valid);
        end
        vecs++;
        if (if_a.link_status !== 1'b0) begin
            errs++;
            $display("FAIL rst_link: got %b want 0", if_a.link_status);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // From a zeroed LFSR and seed 7FF, bits 9 and 10 are inconsistent,
    // so the 60-bit run spans bits 11..70 and lock lands in cycle 35.
    task automatic test_acquire;
        scr = 11'h7FF;
        for (int i = 0; i < 36; i++) begin
            send(1'b1, 1'b1, 2'd2, 1'b0);
            if (i == 34) begin
                vecs++;
                if (if_a.link_status !== 1'b0) begin
                    errs++;
                    $display("FAIL acq_early: got %b want 0", if_a.link_status);
                end
            end
        end
        vecs++;
        if (if_a.link_status !== 1'b1) begin
            errs++;
            $display("FAIL acq_link: got %b want 1", if_a.link_status);
        end
        vecs++;
        if (if_a.bits_valid !== 2'd0) begin
            errs++;
            $display("FAIL acq_bv_lockcyc: got %0d want 0", if_a.bits_valid);
        end
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 1'b1, 2'd2, 1'b0);
            vecs++;
            if (if_a.bits !== 2'b11 || if_a.bits_valid !== 2'd2) begin
                errs++;
                $display("FAIL acq_idle: got %b/%0d want 11/2",
                         if_a.bits, if_a.bits_valid);
            end
        end
        vecs++;
        if (if_b.link_status !== 1'b1) begin
            errs++;
            $display("FAIL acq_link_b: got %b want 1", if_b.link_status);
        end
    endtask

    task automatic test_frame;
        logic [29:0] fr;
        int          vp [4];
        int          pos;
        logic [1:0]  v;
        logic        a, b;
        fr = 30'b11000_10001_01011_11011_01101_00111;
        vp = '{2, 1, 0, 2};
        pos = 29;
        for (int j = 0; j < 24; j++) begin
            v = 2'(vp[j % 4]);
            a = 1'b1;
            b = 1'b1;
            if (v != 2'd0) begin
                a = fr[pos];
                pos--;
            end
            if (v == 2'd2) begin
                b = fr[pos];
                pos--;
            end
            send(a, b, v, 1'b0);
            vecs++;
            if (if_a.bits_valid !== v) begin
                errs++;
                $display("FAIL frame_bv[%0d]: got %0d want %0d",
                         j, if_a.bits_valid, v);
            end
            if (v != 2'd0) begin
                vecs++;
                if (if_a.bits !== {a, b}) begin
                    errs++;
                    $display("FAIL frame_bits[%0d]: got %b want %b",
                             j, if_a.bits, {a, b});
                end
            end
        end
        repeat (20) send(1'b1, 1'b1, 2'd2, 1'b0);
    endtask

    task automatic test_signal_drop;
        sig = 1'b0;
        send(1'b1, 1'b1, 2'd2, 1'b0);
        sig = 1'b1;
        vecs++;
        if (if_a.bits_valid !== 2'd0 || if_a.link_status !== 1'b0) begin
            errs++;
            $display("FAIL drop_out: got %0d/%b want 0/0",
                     if_a.bits_valid, if_a.link_status);
        end
        for (int i = 1; i <= 30; i++) begin
            send(1'b1, 1'b1, 2'd2, 1'b0);
            if (i == 29) begin
                vecs++;
                if (if_a.link_status !== 1'b0) begin
                    errs++;
                    $display("FAIL drop_early: got %b want 0", if_a.link_status);
                end
            end
        end
        vecs++;
        if (if_a.link_status !== 1'b1) begin
            errs++;
            $display("FAIL drop_relock: got %b want 1", if_a.link_status);
        end
        send(1'b1, 1'b1, 2'd2, 1'b0);
        vecs++;
        if (if_a.bits_valid !== 2'd2 || if_a.bits !== 2'b11) begin
            errs++;
            $display("FAIL drop_resume: got %b/%0d want 11/2",
                     if_a.bits, if_a.bits_valid);
        end
        repeat (20) send(1'b1, 1'b1, 2'd2, 1'b0);
    endtask

    // After the last idle cycle the timer is 0; cycle n of the 0/1 pattern
    // leaves it at n+1, so it reaches 100 in pattern cycle 99.
    task automatic test_timeout;
        for (int n = 0; n < 100; n++) begin
            send(1'b0, 1'b1, 2'd2, 1'b0);
            if (n == 98) begin
                vecs++;
                if (if_b.link_status !== 1'b1 || if_b.bits_valid !== 2'd2) begin
                    errs++;
                    $display("FAIL to_hold: got %b/%0d want 1/2",
                             if_b.link_status, if_b.bits_valid);
                end
                vecs++;
                if (if_b.bits !== 2'b01) begin
                    errs++;
                    $display("FAIL to_data: got %b want 01", if_b.bits);
                end
            end
        end
        vecs++;
        if (if_b.link_status !== 1'b0 || if_b.bits_valid !== 2'd0) begin
            errs++;
            $display("FAIL to_drop: got %b/%0d want 0/0",
                     if_b.link_status, if_b.bits_valid);
        end
        vecs++;
        if (if_a.link_status !== 1'b1 || if_a.bits !== 2'b01) begin
            errs++;
            $display("FAIL to_default_held: got %b/%b want 1/01",
                     if_a.link_status, if_a.bits);
        end
        for (int i = 1; i <= 30; i++) begin
            send(1'b1, 1'b1, 2'd2, 1'b0);
            if (i == 29) begin
                vecs++;
                if (if_b.link_status !== 1'b0) begin
                    errs++;
                    $display("FAIL to_early: got %b want 0", if_b.link_status);
                end
            end
        end
        vecs++;
        if (if_b.link_status !== 1'b1) begin
            errs++;
            $display("FAIL to_relock: got %b want 1", if_b.link_status);
        end
    endtask

    // Bit 40 inverted: the bad LFSR bit reaches taps 8 and 10 at bits 49
    // and 51, so the good run is 52..111 and lock lands in cycle 55.
    task automatic test_bit_error;
        @(negedge clk);
        rst_n = 1'b0;
        sv = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        scr = 11'h7FF;
        for (int i = 0; i < 56; i++) begin
            send(1'b1, 1'b1, 2'd2, (i == 20) ? 1'b1 : 1'b0);
            if (i == 35 || i == 54) begin
                vecs++;
                if (if_a.link_status !== 1'b0) begin
                    errs++;
                    $display("FAIL err_early[%0d]: got %b want 0",
                             i, if_a.link_status);
                end
            end
        end
        vecs++;
        if (if_a.link_status !== 1'b1) begin
            errs++;
            $display("FAIL err_lock: got %b want 1", if_a.link_status);
        end
    endtask

    task automatic test_async_reset;
        repeat (3) send(1'b1, 1'b1, 2'd2, 1'b0);
        send(1'b1, 1'b1, 2'd2, 1'b0);
        send(1'b0, 1'b0, 2'd2, 1'b0);
        vecs++;
        if (if_a.bits !== 2'b00 || if_a.link_status !== 1'b1) begin
            errs++;
            $display("FAIL ar_pre: got %b/%b want 00/1",
                     if_a.bits, if_a.link_status);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vecs++;
        if (if_a.bits !== 2'b11 || if_a.bits_valid !== 2'd0 ||
            if_a.link_status !== 1'b0) begin
            errs++;
            $display("FAIL ar_async: got %b/%0d/%b want 11/0/0",
                     if_a.bits, if_a.bits_valid, if_a.link_status);
        end
        sv = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_acquire();
        test_frame();
        test_signal_drop();
        test_timeout();
        test_bit_error();
        test_async_reset();
        test_acquire();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
